// File: rtl/rv32i_pkg.sv
// rv32i_pkg: branch funct3 encodings, 2-bit predictor states and saturating counter step
package rv32i_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    return taken ? ((c == ST) ? c : c + 2'd1) : ((c == SNT) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/bht_counter_array.sv
// bht_counter_array: 2-bit saturating counters, async read port, sync write port (clk, rst_n, rd_idx_i/rd_ctr_o, we_i/wr_idx_i/wr_taken_i)
module bht_counter_array
  import rv32i_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] CTR_INIT = 2'b01,
  localparam int        IW       = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx_i,
  output logic [1:0]    rd_ctr_o,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic          wr_taken_i
);
  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d;
  assign ctr_d    = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
  assign rd_ctr_o = ctr_q[rd_idx_i];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (we_i) begin
      ctr_q[wr_idx_i] <= ctr_d;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal predictor at fetch, branch resolve/mispredict at execute, saturating perf counters
module branch_predict_unit
  import rv32i_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_zero,
  input  logic            ex_less,
  input  logic            ex_lessu,
  input  logic            ex_pred_taken,
  output logic            pc_src,
  output logic            mispredict,
  output logic            illegal_branch,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic        cond, reserved, we;
  logic [1:0]  rd_ctr;
  logic [31:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;
  logic        unused_bits;
  always_comb begin
    cond = (ex_funct3 == F3_BEQ)  ?  ex_zero  :
           (ex_funct3 == F3_BNE)  ? ~ex_zero  :
           (ex_funct3 == F3_BLT)  ?  ex_less  :
           (ex_funct3 == F3_BGE)  ? ~ex_less  :
           (ex_funct3 == F3_BLTU) ?  ex_lessu :
           (ex_funct3 == F3_BGEU) ? ~ex_lessu : 1'b0;
    reserved       = ex_funct3[2:1] == 2'b01;
    illegal_branch = ex_valid & ex_branch & ~ex_jump & reserved;
    pc_src         = ex_valid & (ex_jump | (ex_branch & cond));
    mispredict     = ex_valid & (ex_branch | ex_jump) & ~illegal_branch & (pc_src ^ ex_pred_taken);
    // jumps are always taken, so they never train the counters
    we             = ex_valid & ex_branch & ~ex_jump & ~reserved & ~ex_stall;
    branch_cnt_d   = (ex_valid & (ex_branch | ex_jump) & ~ex_stall & ~&branch_cnt_q) ?
                     branch_cnt_q + 32'd1 : branch_cnt_q;
    mispredict_cnt_d = (mispredict & ~ex_stall & ~&mispredict_cnt_q) ?
                       mispredict_cnt_q + 32'd1 : mispredict_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end
  bht_counter_array #(.ENTRIES(BHT_ENTRIES), .CTR_INIT(CTR_INIT)) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (if_pc[IW+1:2]),
    .rd_ctr_o   (rd_ctr),
    .we_i       (we),
    .wr_idx_i   (ex_pc[IW+1:2]),
    .wr_taken_i (pc_src)
  );
  assign pred_taken     = rd_ctr[1];
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign unused_bits    = ^{if_pc[XLEN-1:IW+2], if_pc[1:0], ex_pc[XLEN-1:IW+2], ex_pc[1:0], rd_ctr[0]};
endmodule
